avalon_mm_arbiter_master: RTL and testbench
===========================================

# avalon_mm_arbiter_master

Parametrised Avalon-MM master that arbitrates NCH independent requesters (core instruction fetch, core data port, debug bridge, …) onto one Avalon-MM master port. It generalises the fixed one-requester-per-master arrangement: configurable channel count and address/data widths, per-channel locking, waitrequest timeout with error reporting, and fixed-priority or round-robin arbitration. It sits between the core/debug interconnect logic and the Qsys fabric.

## Interface
Parameters:
- NCH, 3: number of requester channels; legal range 2..8.
- AW, 32: address width.
- DW, 32: data width.
- TIMEOUT, 0: maximum number of WAITREQUEST-stalled cycles before a transfer is aborted; 0 disables the timeout.

Ports:
- CLK  in  1  single clock for all logic.
- RST_N  in  1  asynchronous, active-low reset.
- req_start  in  NCH  per-channel single-cycle request pulse.
- req_rnw  in  NCH  1 = read, 0 = write.
- req_lock  in  NCH  keeps the bus on this channel after the transfer completes.
- req_addr  in  NCH*AW  channel i occupies bits [i*AW +: AW].
- req_wdata  in  NCH*DW  channel i occupies bits [i*DW +: DW].
- req_done  out  NCH  one-cycle completion pulse for the owning channel.
- req_err  out  NCH  one-cycle pulse, coincident with req_done, when the transfer timed out.
- req_rdata  out  DW  shared read data, valid while req_done is high.
- ADDRESS  out  AW  Avalon address.
- BEGINTRANSFER  out  1  Avalon begintransfer.
- READ  out  1  Avalon read.
- WRITE  out  1  Avalon write.
- WRITEDATA  out  DW  Avalon write data.
- LOCK  out  1  Avalon lock.
- READDATA  in  DW  Avalon read data.
- WAITREQUEST  in  1  Avalon waitrequest.

## Operation
- Each channel has a pending bit, set by req_start. A req_start on a channel that is already pending is ignored. If req_start and req_done occur in the same cycle on the same channel, the pending bit ends up set, so the new request wins.
- A requester holds req_addr, req_rnw, req_wdata and req_lock stable from its req_start pulse until its req_done pulse.
- The FSM has two states:
  - IDLE: if any pending bit is set, select grant g according to the arbitration rule. On the clock edge, register ADDRESS, WRITEDATA, READ = rnw, WRITE = ~rnw, BEGINTRANSFER = 1, LOCK = req_lock[g], and latch lk = req_lock[g]. Go to BUS.
  - BUS: BEGINTRANSFER is high only in the first BUS cycle. When WAITREQUEST = 0 at a clock edge:
    - capture READDATA into req_rdata (writes leave req_rdata unchanged);
    - clear READ, WRITE and LOCK;
    - pulse req_done[g];
    - clear pending[g];
    - go to IDLE.
- Timeout (TIMEOUT > 0): a stall counter increments on every BUS cycle with WAITREQUEST = 1.
  - When the counter reaches TIMEOUT, the transfer terminates as above with req_rdata = 0 and req_err[g] = 1.
  - The counter clears on every grant.
- Lock: while lk = 1 after completion, IDLE grants only channel g; other channels stay pending. lk clears when g completes a transfer issued with req_lock = 0 (normal completion or timeout).
- Arbitration: fixed priority, lowest channel index wins, unless round robin is compiled in (see Configuration).
- Counter width is $clog2(TIMEOUT+1). Address and data are passed through without modification.

## Timing
- Reset (async assert, synchronous release): all outputs 0, req_rdata 0, pending 0, lk 0, FSM in IDLE, round-robin pointer 0.
- Minimum latency:
  - cycle 0: req_start high;
  - cycle 1: pending;
  - cycle 2: READ/WRITE and BEGINTRANSFER asserted; if WAITREQUEST = 0, the transfer is accepted at the end of this cycle;
  - cycle 3: req_done high.
- Each WAITREQUEST cycle adds one cycle. READ/WRITE and all command signals are held stable for as long as WAITREQUEST = 1.
- Throughput: there is one IDLE cycle between consecutive transfers, so at most one transfer per 2 cycles.
- Reset asserted mid-transfer: READ and WRITE drop immediately, the transfer is abandoned, and no req_done is produced.
- req_done and req_err are never high for more than one cycle, and never for more than one channel at a time.

## Configuration
- AVMM_ARB_ROUND_ROBIN_EN defined: round-robin arbitration. The pointer moves to g+1 (mod NCH) after each grant, and the search starts at the pointer. Lock overrides the pointer.
- AVMM_ARB_ROUND_ROBIN_EN undefined: fixed priority with channel 0 highest. No pointer register is built.

## Test plan
- Single read, NCH = 3: ch1 issues a read of 0x0000_0100, WAITREQUEST = 0, READDATA = 0xCAFE_0001 → READ is high in cycle 2 only, BEGINTRANSFER is high in cycle 2, req_done[1] = 1 with req_rdata = 0xCAFE_0001 in cycle 3.
- Stalled write: ch0 issues a write of 0x1234_5678 to 0x0000_0040, WAITREQUEST = 1 for 4 cycles → WRITE and WRITEDATA are stable for 5 cycles, BEGINTRANSFER is high for the first cycle only, req_done[0] pulses once.
- Contention: ch0, ch1 and ch2 pulse req_start in the same cycle → fixed priority grants 0, 1, 2; with AVMM_ARB_ROUND_ROBIN_EN and a second burst of the same three requests, the order is 0, 1, 2 then 0, 1, 2. Transfers are spaced 2 cycles apart when WAITREQUEST = 0.
- Lock: ch2 performs two transfers, the first with req_lock = 1; ch0 is pending throughout → ch0 is granted only after ch2's unlocked transfer completes, and LOCK is high during the first transfer.
- Timeout: TIMEOUT = 8, WAITREQUEST held at 1 → req_done[g] and req_err[g] = 1 with req_rdata = 0 after 8 stall cycles, READ drops, the next pending channel proceeds.
- Reset mid-transfer: RST_N driven low while READ = 1 → READ is 0 immediately, no req_done; after release, a new request completes normally.

Source files
------------

// File: rtl/avalon_mm_arbiter_master.sv
// Purpose : arbitrates NCH requester channels onto one Avalon-MM master port.
// Latency : req_start -> command on bus 2 cycles; acceptance -> req_done 1 cycle.
// Backpres: WAITREQUEST holds all command signals; optional TIMEOUT aborts with req_err.
//
// Ports: CLK/RST_N (async active-low); per-channel req_start/rnw/lock/addr/wdata in,
//        req_done/req_err pulses and shared req_rdata out; Avalon ADDRESS, BEGINTRANSFER,
//        READ, WRITE, WRITEDATA, LOCK out; READDATA, WAITREQUEST in.
// Config : define AVMM_ARB_ROUND_ROBIN_EN for round-robin arbitration
//          (default: fixed priority, channel 0 highest).
module avalon_mm_arbiter_master #(
    parameter int NCH     = 3,
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 0
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic [NCH-1:0]    req_start,
    input  logic [NCH-1:0]    req_rnw,
    input  logic [NCH-1:0]    req_lock,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH*DW-1:0] req_wdata,
    output logic [NCH-1:0]    req_done,
    output logic [NCH-1:0]    req_err,
    output logic [DW-1:0]     req_rdata,
    output logic [AW-1:0]     ADDRESS,
    output logic              BEGINTRANSFER,
    output logic              READ,
    output logic              WRITE,
    output logic [DW-1:0]     WRITEDATA,
    output logic              LOCK,
    input  logic [DW-1:0]     READDATA,
    input  logic              WAITREQUEST
);

    localparam int GW = $clog2(NCH);
    // A zero-width counter is illegal, so keep one bit when the timeout is disabled.
    localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic {IDLE, BUS} state_t;

    state_t          state, state_nxt;
    logic [NCH-1:0]  pending, pending_nxt, clr;
    logic [GW-1:0]   g, g_nxt;
    logic            lk, lk_nxt;
    logic [CW-1:0]   stall_cnt, cnt_nxt;
    logic            timeout_hit;
    logic            sel_vld;
    logic [GW-1:0]   sel_idx;
    logic [AW-1:0]   addr_nxt;
    logic [DW-1:0]   wdata_nxt, rdata_nxt;
    logic            read_nxt, write_nxt, bt_nxt, lock_nxt;
    logic [NCH-1:0]  done_nxt, err_nxt;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
    logic [GW-1:0]   rr_ptr, rr_ptr_nxt;
    logic [GW:0]     rr_idx;
`endif

    // Grant selection. A held lock restricts the choice to the locked channel.
    always_comb begin
        sel_vld = 1'b0;
        sel_idx = '0;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
        rr_idx  = '0;
`endif
        if (lk) begin
            if (pending[g]) begin
                sel_vld = 1'b1;
                sel_idx = g;
            end
        end else begin
`ifdef AVMM_ARB_ROUND_ROBIN_EN
            // Walk down so the last hit is the one closest to the pointer.
            for (int k = NCH - 1; k >= 0; k--) begin
                rr_idx = {1'b0, rr_ptr} + (GW+1)'(k);
                if (rr_idx >= (GW+1)'(NCH))
                    rr_idx = rr_idx - (GW+1)'(NCH);
                if (pending[rr_idx[GW-1:0]]) begin
                    sel_vld = 1'b1;
                    sel_idx = rr_idx[GW-1:0];
                end
            end
`else
            for (int i = NCH - 1; i >= 0; i--) begin
                if (pending[i]) begin
                    sel_vld = 1'b1;
                    sel_idx = GW'(i);
                end
            end
`endif
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_nxt   = state;
        g_nxt       = g;
        lk_nxt      = lk;
        cnt_nxt     = stall_cnt;
        addr_nxt    = ADDRESS;
        wdata_nxt   = WRITEDATA;
        read_nxt    = READ;
        write_nxt   = WRITE;
        bt_nxt      = BEGINTRANSFER;
        lock_nxt    = LOCK;
        rdata_nxt   = req_rdata;
        done_nxt    = '0;
        err_nxt     = '0;
        clr         = '0;
        timeout_hit = 1'b0;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
        rr_ptr_nxt  = rr_ptr;
`endif
        // The counter value is the number of stalls already seen, so this
        // stall is the TIMEOUT-th one when it equals TIMEOUT-1.
        if (TIMEOUT > 0)
            timeout_hit = WAITREQUEST && (stall_cnt == CW'(TIMEOUT - 1));

        case (state)
            IDLE: begin
                if (sel_vld) begin
                    state_nxt = BUS;
                    g_nxt     = sel_idx;
                    addr_nxt  = req_addr[sel_idx*AW +: AW];
                    wdata_nxt = req_wdata[sel_idx*DW +: DW];
                    read_nxt  = req_rnw[sel_idx];
                    write_nxt = ~req_rnw[sel_idx];
                    bt_nxt    = 1'b1;
                    lock_nxt  = req_lock[sel_idx];
                    lk_nxt    = req_lock[sel_idx];
                    cnt_nxt   = '0;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
                    rr_ptr_nxt = (sel_idx == GW'(NCH - 1)) ? '0 : sel_idx + 1'b1;
`endif
                end
            end
            BUS: begin
                bt_nxt = 1'b0;
                if (!WAITREQUEST || timeout_hit) begin
                    state_nxt   = IDLE;
                    read_nxt    = 1'b0;
                    write_nxt   = 1'b0;
                    lock_nxt    = 1'b0;
                    done_nxt[g] = 1'b1;
                    clr[g]      = 1'b1;
                    // lk keeps the value latched at grant: an unlocked
                    // transfer completing is what releases the lock.
                    if (timeout_hit) begin
                        err_nxt[g] = 1'b1;
                        rdata_nxt  = '0;
                    end else if (READ) begin
                        rdata_nxt  = READDATA;
                    end
                end else if (TIMEOUT > 0) begin
                    cnt_nxt = stall_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        // A new start on a completing channel re-arms it.
        pending_nxt = (pending & ~clr) | req_start;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state         <= IDLE;
            pending       <= '0;
            g             <= '0;
            lk            <= 1'b0;
            stall_cnt     <= '0;
            ADDRESS       <= '0;
            WRITEDATA     <= '0;
            READ          <= 1'b0;
            WRITE         <= 1'b0;
            BEGINTRANSFER <= 1'b0;
            LOCK          <= 1'b0;
            req_rdata     <= '0;
            req_done      <= '0;
            req_err       <= '0;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
            rr_ptr        <= '0;
`endif
        end else begin
            state         <= state_nxt;
            pending       <= pending_nxt;
            g             <= g_nxt;
            lk            <= lk_nxt;
            stall_cnt     <= cnt_nxt;
            ADDRESS       <= addr_nxt;
            WRITEDATA     <= wdata_nxt;
            READ          <= read_nxt;
            WRITE         <= write_nxt;
            BEGINTRANSFER <= bt_nxt;
            LOCK          <= lock_nxt;
            req_rdata     <= rdata_nxt;
            req_done      <= done_nxt;
            req_err       <= err_nxt;
`ifdef AVMM_ARB_ROUND_ROBIN_EN
            rr_ptr        <= rr_ptr_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_avalon_mm_arbiter_master.sv
// Directed bench for avalon_mm_arbiter_master (NCH=3, TIMEOUT=8).
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_avalon_mm_arbiter_master;

    localparam int NCH = 3;
    localparam int AW  = 32;
    localparam int DW  = 32;

    logic              CLK;
    logic              RST_N;
    logic [NCH-1:0]    req_start, req_rnw, req_lock;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH*DW-1:0] req_wdata;
    logic [NCH-1:0]    req_done, req_err;
    logic [DW-1:0]     req_rdata;
    logic [AW-1:0]     ADDRESS;
    logic              BEGINTRANSFER, READ, WRITE, LOCK;
    logic [DW-1:0]     WRITEDATA, READDATA;
    logic              WAITREQUEST;

    int n_assert = 0;
    int n_fail   = 0;

    avalon_mm_arbiter_master #(.NCH(NCH), .AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .req_start(req_start), .req_rnw(req_rnw), .req_lock(req_lock),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .req_err(req_err), .req_rdata(req_rdata),
        .ADDRESS(ADDRESS), .BEGINTRANSFER(BEGINTRANSFER), .READ(READ), .WRITE(WRITE),
        .WRITEDATA(WRITEDATA), .LOCK(LOCK), .READDATA(READDATA), .WAITREQUEST(WAITREQUEST)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_req(input int ch, input logic rnw, input logic lck,
                           input logic [31:0] a, input logic [31:0] d);
        req_rnw[ch]            = rnw;
        req_lock[ch]           = lck;
        req_addr[ch*AW +: AW]  = a;
        req_wdata[ch*DW +: DW] = d;
    endtask

    initial begin
        RST_N = 1'b0;
        req_start = '0; req_rnw = '0; req_lock = '0;
        req_addr = '0; req_wdata = '0;
        READDATA = '0; WAITREQUEST = 1'b0;

        // ---------------- reset state
        tick(); tick();
        chk("rst_read",  {31'd0, READ}, 32'd0);
        chk("rst_write", {31'd0, WRITE}, 32'd0);
        chk("rst_bt",    {31'd0, BEGINTRANSFER}, 32'd0);
        chk("rst_lock",  {31'd0, LOCK}, 32'd0);
        chk("rst_done",  {29'd0, req_done}, 32'd0);
        chk("rst_err",   {29'd0, req_err}, 32'd0);
        chk("rst_rdata", req_rdata, 32'd0);
        chk("rst_addr",  ADDRESS, 32'd0);
        RST_N = 1'b1;
        tick();

        // ---------------- single read on ch1, no wait states
        set_req(1, 1'b1, 1'b0, 32'h0000_0100, 32'h0);
        req_start = 3'b010;                       // cycle 0
        tick(); req_start = '0;                   // cycle 1
        chk("rd_c1_read", {31'd0, READ}, 32'd0);
        tick();                                   // cycle 2
        chk("rd_c2_read", {31'd0, READ}, 32'd1);
        chk("rd_c2_bt",   {31'd0, BEGINTRANSFER}, 32'd1);
        chk("rd_c2_write",{31'd0, WRITE}, 32'd0);
        chk("rd_c2_addr", ADDRESS, 32'h0000_0100);
        READDATA = 32'hCAFE_0001;
        tick();                                   // cycle 3
        chk("rd_c3_done", {29'd0, req_done}, 32'b010);
        chk("rd_c3_rdata", req_rdata, 32'hCAFE_0001);
        chk("rd_c3_read", {31'd0, READ}, 32'd0);
        chk("rd_c3_err",  {29'd0, req_err}, 32'd0);
        READDATA = 32'hDEAD_BEEF;
        tick();
        chk("rd_c4_done", {29'd0, req_done}, 32'd0);

        // ---------------- stalled write on ch0, 4 wait states
        set_req(0, 1'b0, 1'b0, 32'h0000_0040, 32'h1234_5678);
        req_start = 3'b001; WAITREQUEST = 1'b1;
        tick(); req_start = '0;
        for (int k = 0; k < 5; k++) begin
            tick();                               // cycles 2..6
            if (k == 4) WAITREQUEST = 1'b0;
            chk($sformatf("wr_stall%0d_write", k), {31'd0, WRITE}, 32'd1);
            chk($sformatf("wr_stall%0d_wdata", k), WRITEDATA, 32'h1234_5678);
            chk($sformatf("wr_stall%0d_addr", k), ADDRESS, 32'h0000_0040);
            chk($sformatf("wr_stall%0d_bt", k), {31'd0, BEGINTRANSFER}, (k == 0) ? 32'd1 : 32'd0);
            chk($sformatf("wr_stall%0d_done", k), {29'd0, req_done}, 32'd0);
        end
        tick();                                   // cycle 7
        chk("wr_done",  {29'd0, req_done}, 32'b001);
        chk("wr_write", {31'd0, WRITE}, 32'd0);
        chk("wr_rdata_kept", req_rdata, 32'hCAFE_0001);
        tick();
        chk("wr_done_once", {29'd0, req_done}, 32'd0);

        // ---------------- contention, two bursts of three reads
        set_req(0, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
        set_req(1, 1'b1, 1'b0, 32'h0000_2000, 32'h0);
        set_req(2, 1'b1, 1'b0, 32'h0000_3000, 32'h0);
        for (int b = 0; b < 2; b++) begin
            req_start = 3'b111;
            tick(); req_start = '0;
            for (int ch = 0; ch < 3; ch++) begin
                tick();
                chk($sformatf("ct%0d_ch%0d_read", b, ch), {31'd0, READ}, 32'd1);
                chk($sformatf("ct%0d_ch%0d_addr", b, ch), ADDRESS, 32'h0000_1000 * (ch + 1));
                READDATA = 32'hA000_0000 + 32'(b * 16 + ch);
                tick();
                chk($sformatf("ct%0d_ch%0d_done", b, ch), {29'd0, req_done}, 32'(1 << ch));
                chk($sformatf("ct%0d_ch%0d_rdata", b, ch), req_rdata, 32'hA000_0000 + 32'(b * 16 + ch));
                chk($sformatf("ct%0d_ch%0d_idle", b, ch), {31'd0, READ}, 32'd0);
            end
        end
        tick();

        // ---------------- lock: ch2 locked then unlocked, ch0 waits
        set_req(2, 1'b1, 1'b1, 32'h0000_2200, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h0000_0300, 32'h0);
        req_start = 3'b100;                       // cycle 0
        tick(); req_start = 3'b001;               // cycle 1
        tick(); req_start = '0;                   // cycle 2
        chk("lk_c2_read", {31'd0, READ}, 32'd1);
        chk("lk_c2_addr", ADDRESS, 32'h0000_2200);
        chk("lk_c2_lock", {31'd0, LOCK}, 32'd1);
        tick();                                   // cycle 3
        chk("lk_c3_done", {29'd0, req_done}, 32'b100);
        chk("lk_c3_lock", {31'd0, LOCK}, 32'd0);
        set_req(2, 1'b1, 1'b0, 32'h0000_2204, 32'h0);
        req_start = 3'b100;
        tick(); req_start = '0;                   // cycle 4
        chk("lk_c4_held", {31'd0, READ}, 32'd0);
        tick();                                   // cycle 5
        chk("lk_c5_read", {31'd0, READ}, 32'd1);
        chk("lk_c5_addr", ADDRESS, 32'h0000_2204);
        chk("lk_c5_lock", {31'd0, LOCK}, 32'd0);
        tick();                                   // cycle 6
        chk("lk_c6_done", {29'd0, req_done}, 32'b100);
        tick();                                   // cycle 7
        chk("lk_c7_read", {31'd0, READ}, 32'd1);
        chk("lk_c7_addr", ADDRESS, 32'h0000_0300);
        tick();                                   // cycle 8
        chk("lk_c8_done", {29'd0, req_done}, 32'b001);
        tick();

        // ---------------- timeout after 8 stalls on ch1, ch0 next
        set_req(1, 1'b1, 1'b0, 32'h0000_0500, 32'h0);
        set_req(0, 1'b1, 1'b0, 32'h0000_0600, 32'h0);
        WAITREQUEST = 1'b1; READDATA = 32'h5555_AAAA;
        req_start = 3'b010;
        tick(); req_start = 3'b001;
        for (int k = 0; k < 8; k++) begin
            tick(); req_start = '0;               // cycles 2..9
            chk($sformatf("to_stall%0d_read", k), {31'd0, READ}, 32'd1);
            chk($sformatf("to_stall%0d_done", k), {29'd0, req_done}, 32'd0);
        end
        tick();                                   // cycle 10
        chk("to_done",  {29'd0, req_done}, 32'b010);
        chk("to_err",   {29'd0, req_err}, 32'b010);
        chk("to_rdata", req_rdata, 32'd0);
        chk("to_read",  {31'd0, READ}, 32'd0);
        WAITREQUEST = 1'b0;
        tick();                                   // cycle 11
        chk("to_next_read", {31'd0, READ}, 32'd1);
        chk("to_next_addr", ADDRESS, 32'h0000_0600);
        chk("to_err_once",  {29'd0, req_err}, 32'd0);
        tick();                                   // cycle 12
        chk("to_next_done", {29'd0, req_done}, 32'b001);
        chk("to_next_err",  {29'd0, req_err}, 32'd0);
        chk("to_next_rdata", req_rdata, 32'h5555_AAAA);
        tick();

        // ---------------- reset asserted mid-transfer
        WAITREQUEST = 1'b1;
        req_start = 3'b001;
        tick(); req_start = '0;
        tick();
        chk("mr_read_before", {31'd0, READ}, 32'd1);
        #2 RST_N = 1'b0;
        #1;
        chk("mr_read_now", {31'd0, READ}, 32'd0);
        tick();
        chk("mr_done_in_rst", {29'd0, req_done}, 32'd0);
        chk("mr_rdata_clr", req_rdata, 32'd0);
        RST_N = 1'b1; WAITREQUEST = 1'b0;
        tick();
        chk("mr_no_done", {29'd0, req_done}, 32'd0);
        chk("mr_idle", {31'd0, READ}, 32'd0);
        set_req(1, 1'b1, 1'b0, 32'h0000_0700, 32'h0);
        READDATA = 32'h0BAD_F00D;
        req_start = 3'b010;
        tick(); req_start = '0;
        tick();
        chk("mr_new_read", {31'd0, READ}, 32'd1);
        chk("mr_new_addr", ADDRESS, 32'h0000_0700);
        tick();
        chk("mr_new_done", {29'd0, req_done}, 32'b010);
        chk("mr_new_rdata", req_rdata, 32'h0BAD_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
